rename_table: RTL

RENAME_TABLE -- requirements
Module: rename_table

---
 rtl/rename_table_if.sv | 64 ++++++
 rtl/rename_table.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/rename_table_if.sv
// Bus bundle for rename_table: decode group in, freelist, rename result out, commit and release.
// The io_stall_cnt member exists only when RENAME_STALL_CNT_EN is defined.
interface rename_table_if;
    localparam int unsigned NL = 4;
    localparam int unsigned AW = 5;
    localparam int unsigned PW = 6;

    logic                   in_valid;
    logic                   in_ready;
    logic [NL-1:0]          in_vld;
    logic [NL-1:0]          in_wen;
    logic [NL-1:0][AW-1:0]  in_rd;
    logic [NL-1:0][AW-1:0]  in_rs1;
    logic [NL-1:0][AW-1:0]  in_rs2;

    logic [NL-1:0]          fl_req;
    logic [NL-1:0][PW-1:0]  fl_pidx;
    logic [NL-1:0]          fl_pvld;
    logic                   fl_busy;

    logic                   out_valid;
    logic                   out_ready;
    logic [NL-1:0]          out_vld;
    logic [NL-1:0][PW-1:0]  out_prs1;
    logic [NL-1:0][PW-1:0]  out_prs2;
    logic [NL-1:0][PW-1:0]  out_prd;
    logic [NL-1:0][PW-1:0]  out_oldprd;

    logic [NL-1:0]          cmt_vld;
    logic [NL-1:0][AW-1:0]  cmt_rd;
    logic [NL-1:0][PW-1:0]  cmt_prd;

    logic [NL-1:0]          rls;
    logic [NL-1:0][PW-1:0]  rls_pidx;

    logic                   flush;
`ifdef RENAME_STALL_CNT_EN
    logic [31:0]            stall_cnt;
`endif

    modport slave (
        input  in_valid, in_vld, in_wen, in_rd, in_rs1, in_rs2,
        input  fl_pidx, fl_pvld, fl_busy, out_ready,
        input  cmt_vld, cmt_rd, cmt_prd, flush,
        output in_ready, fl_req, out_valid, out_vld,
        output out_prs1, out_prs2, out_prd, out_oldprd,
        output rls, rls_pidx
`ifdef RENAME_STALL_CNT_EN
        , output stall_cnt
`endif
    );

    modport master (
        output in_valid, in_vld, in_wen, in_rd, in_rs1, in_rs2,
        output fl_pidx, fl_pvld, fl_busy, out_ready,
        output cmt_vld, cmt_rd, cmt_prd, flush,
        input  in_ready, fl_req, out_valid, out_vld,
        input  out_prs1, out_prs2, out_prd, out_oldprd,
        input  rls, rls_pidx
`ifdef RENAME_STALL_CNT_EN
        , input stall_cnt
`endif
    );
endinterface

// File: rtl/rename_table.sv
// 4-wide register rename table: speculative (SRT) and architectural (ART) maps, intra-group bypass,
// commit-time release and flush recovery. Define RENAME_STALL_CNT_EN to add the stall cycle counter.
module rename_table (
    input  logic          clock,
    input  logic          reset,
    rename_table_if.slave io
);
    localparam int unsigned NL   = 4;
    localparam int unsigned AW   = 5;
    localparam int unsigned PW   = 6;
    localparam int unsigned NREG = 32;

    logic [NREG-1:0][PW-1:0] srt_q, srt_d;
    logic [NREG-1:0][PW-1:0] art_q, art_d;

    logic                  out_valid_q, out_valid_d;
    logic [NL-1:0]         out_vld_q, out_vld_d;
    logic [NL-1:0][PW-1:0] prs1_q, prs1_d;
    logic [NL-1:0][PW-1:0] prs2_q, prs2_d;
    logic [NL-1:0][PW-1:0] prd_q, prd_d;
    logic [NL-1:0][PW-1:0] oldprd_q, oldprd_d;
    logic [NL-1:0]         rls_q, rls_d;
    logic [NL-1:0][PW-1:0] rls_pidx_q, rls_pidx_d;

    logic [NL-1:0]         need_c;
    logic                  in_ready_c;
    logic                  pvld_ok_c;
    logic                  fire_c;
    logic [NL-1:0][PW-1:0] lk_prs1_c, lk_prs2_c, lk_old_c;

    // Group acceptance: every allocating lane must see a free physical register.
    always_comb begin
        for (int i = 0; i < NL; i++) begin
            need_c[i] = io.in_vld[i] & io.in_wen[i] & (io.in_rd[i] != AW'(0));
        end
        in_ready_c = !io.flush & !io.fl_busy & (!out_valid_q | io.out_ready);
        pvld_ok_c  = &(~need_c | io.fl_pvld);
        fire_c     = !reset & io.in_valid & in_ready_c & pvld_ok_c;
    end

    assign io.in_ready = in_ready_c;
    assign io.fl_req   = fire_c ? need_c : '0;

    // Source lookup: SRT, overridden by the youngest older lane in the group writing the same rd.
    always_comb begin
        for (int j = 0; j < NL; j++) begin
            lk_prs1_c[j] = srt_q[io.in_rs1[j]];
            lk_prs2_c[j] = srt_q[io.in_rs2[j]];
            lk_old_c[j]  = srt_q[io.in_rd[j]];
            for (int k = 0; k < j; k++) begin
                if (need_c[k] && (io.in_rd[k] == io.in_rs1[j])) lk_prs1_c[j] = io.fl_pidx[k];
                if (need_c[k] && (io.in_rd[k] == io.in_rs2[j])) lk_prs2_c[j] = io.fl_pidx[k];
                if (need_c[k] && (io.in_rd[k] == io.in_rd[j]))  lk_old_c[j]  = io.fl_pidx[k];
            end
        end
    end

    // Commit: walk lanes in order so a later lane sees an earlier lane's ART update.
    always_comb begin
        art_d      = art_q;
        rls_d      = '0;
        rls_pidx_d = '0;
        for (int i = 0; i < NL; i++) begin
            if (io.cmt_vld[i] && (io.cmt_rd[i] != AW'(0))) begin
                rls_d[i]              = 1'b1;
                rls_pidx_d[i]         = art_d[io.cmt_rd[i]];
                art_d[io.cmt_rd[i]]   = io.cmt_prd[i];
            end
        end
    end

    // SRT update; flush restores from the post-commit ART and never coincides with fire.
    always_comb begin
        srt_d = srt_q;
        if (io.flush) begin
            srt_d = art_d;
        end else if (fire_c) begin
            for (int i = 0; i < NL; i++) begin
                if (need_c[i]) srt_d[io.in_rd[i]] = io.fl_pidx[i];
            end
        end
    end

    // Result register: load on fire, hold while stalled downstream.
    always_comb begin
        out_valid_d = out_valid_q;
        out_vld_d   = out_vld_q;
        prs1_d      = prs1_q;
        prs2_d      = prs2_q;
        prd_d       = prd_q;
        oldprd_d    = oldprd_q;
        if (fire_c) begin
            out_valid_d = 1'b1;
            out_vld_d   = io.in_vld;
            prs1_d      = lk_prs1_c;
            prs2_d      = lk_prs2_c;
            oldprd_d    = lk_old_c;
            for (int i = 0; i < NL; i++) begin
                prd_d[i] = need_c[i] ? io.fl_pidx[i] : PW'(0);
            end
        end else if (io.flush || io.out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) begin
                srt_q[r] <= PW'(r);
                art_q[r] <= PW'(r);
            end
            out_valid_q <= 1'b0;
            out_vld_q   <= '0;
            prs1_q      <= '0;
            prs2_q      <= '0;
            prd_q       <= '0;
            oldprd_q    <= '0;
            rls_q       <= '0;
            rls_pidx_q  <= '0;
        end else begin
            srt_q       <= srt_d;
            art_q       <= art_d;
            out_valid_q <= out_valid_d;
            out_vld_q   <= out_vld_d;
            prs1_q      <= prs1_d;
            prs2_q      <= prs2_d;
            prd_q       <= prd_d;
            oldprd_q    <= oldprd_d;
            rls_q       <= rls_d;
            rls_pidx_q  <= rls_pidx_d;
        end
    end

    assign io.out_valid  = out_valid_q;
    assign io.out_vld    = out_vld_q;
    assign io.out_prs1   = prs1_q;
    assign io.out_prs2   = prs2_q;
    assign io.out_prd    = prd_q;
    assign io.out_oldprd = oldprd_q;
    assign io.rls        = rls_q;
    assign io.rls_pidx   = rls_pidx_q;

`ifdef RENAME_STALL_CNT_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    // Cycles with a presented group that was not accepted; wraps naturally.
    always_comb begin
        stall_cnt_d = stall_cnt_q + 32'(io.in_valid & !fire_c);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) stall_cnt_q <= '0;
        else       stall_cnt_q <= stall_cnt_d;
    end

    assign io.stall_cnt = stall_cnt_q;
`else
    // Counter and its port are absent in this build.
`endif
endmodule
